// File: rtl/mem_arbiter_pkg.sv
// mem_pkg: shared types and helpers for the unified-memory arbiter
package mem_pkg;
  typedef enum logic [1:0] {MODE_WORD = 2'b00, MODE_HALF = 2'b01, MODE_BYTE = 2'b10} mem_mode_t;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  // Mode 11 falls through to the word rule.
  function automatic logic misaligned(input logic own, input logic [31:0] addr, input logic [1:0] mode);
    return own == OWN_I ? addr[1:0] != 2'b00 :
           mode == MODE_HALF ? addr[0] :
           mode == MODE_BYTE ? 1'b0 : addr[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes plus memory-side bus of the arbiter
interface mem_arbiter_if;
  logic        i_valid, i_ready, i_rvalid, i_err;
  logic [31:0] i_addr;
  logic        d_valid, d_we, d_ready, d_rvalid, d_err;
  logic [31:0] d_addr, d_wd;
  logic [1:0]  d_mode;
  logic [31:0] rdata, mem_adr, mem_wd, mem_rd;
  logic        mem_we;
  logic [1:0]  mem_mode;
  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_we, d_wd, d_mode, mem_rd,
    output i_ready, i_rvalid, i_err, d_ready, d_rvalid, d_err, rdata, mem_adr, mem_wd, mem_we, mem_mode
  );
  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_we, d_wd, d_mode, mem_rd,
    input  i_ready, i_rvalid, i_err, d_ready, d_rvalid, d_err, rdata, mem_adr, mem_wd, mem_we, mem_mode
  );
endinterface

// File: rtl/mem_arbiter_prio.sv
// mem_arb_prio: data-first grant with a starvation counter that forces fetch through
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  input  logic d_valid,
  input  logic eligible,
  output logic grant_i,
  output logic grant_d
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic force_i;
  always_comb begin
    force_i = cnt_q == LIMIT;
    grant_i = eligible & i_valid & (~d_valid | force_i);
    grant_d = eligible & d_valid & ~grant_i;
    cnt_d = grant_i ? '0 : (grant_d & i_valid & ~force_i) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk)
    cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and load/store onto one memory, one access per transaction
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  arb_state_t state_q, state_d;
  logic [31:0] adr_q, adr_d, wd_q, wd_d, rdata_q;
  logic [1:0] mode_q, mode_d;
  logic we_q, we_d, own_q, own_d, err_q;
  logic eligible, grant_i, grant_d, mis;
  assign eligible = (state_q == IDLE || state_q == RESP) & ~reset;
  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_prio (
    .clk(clk), .reset(reset), .i_valid(bus.i_valid), .d_valid(bus.d_valid),
    .eligible(eligible), .grant_i(grant_i), .grant_d(grant_d)
  );
  assign mis = misaligned(own_q, adr_q, mode_q);
  always_comb begin
    state_d = (grant_i | grant_d) ? ACCESS : state_q == ACCESS ? RESP : IDLE;
    own_d = grant_i ? OWN_I : grant_d ? OWN_D : own_q;
    adr_d = grant_i ? bus.i_addr : grant_d ? bus.d_addr : adr_q;
    wd_d = grant_d ? bus.d_wd : wd_q;
    mode_d = grant_d ? bus.d_mode : mode_q;
    we_d = grant_i ? 1'b0 : grant_d ? bus.d_we : we_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      adr_q <= '0;
      wd_q <= '0;
      mode_q <= '0;
      we_q <= 1'b0;
      own_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      wd_q <= wd_d;
      mode_q <= mode_d;
      we_q <= we_d;
      own_q <= own_d;
      if (state_q == ACCESS) begin
        rdata_q <= bus.mem_rd;
        err_q <= mis;
      end
    end
  end
  assign bus.i_ready = grant_i;
  assign bus.d_ready = grant_d;
  assign bus.i_rvalid = state_q == RESP && own_q == OWN_I;
  assign bus.d_rvalid = state_q == RESP && own_q == OWN_D;
  assign bus.i_err = bus.i_rvalid & err_q;
  assign bus.d_err = bus.d_rvalid & err_q;
  assign bus.rdata = rdata_q;
  assign bus.mem_adr = adr_q;
  assign bus.mem_wd = wd_q;
  assign bus.mem_mode = mode_q;
  // Reset gates the strobe so a transaction aborted mid-access never commits.
  assign bus.mem_we = state_q == ACCESS && we_q && !mis && !reset;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench with a byte-level reference memory
module tb_mem_arbiter;
  typedef struct {logic own; logic we; logic [1:0] mode; logic [31:0] addr; logic [31:0] wd; int cyc;} req_t;
  typedef struct {logic own; logic err; logic [31:0] rd; int cyc;} exp_t;
  logic clk = 1'b0, reset = 1'b1, load = 1'b1, zchk = 1'b0, endchk = 1'b0;
  int cyc = 0, checks = 0, failures = 0, starve = 0;
  int i_acc_n = 0, d_acc_n = 0, i_seen = 0, d_seen = 0;
  logic [31:0] mem [64];
  logic [31:0] init [64];
  logic [31:0] ref_mem [64];
  exp_t sb[$];
  req_t pend;
  logic have_pend = 1'b0;
  mem_arbiter_if bus();
  mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.mem_rd = mem[bus.mem_adr[7:2]];
  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 64; k++) mem[k] <= init[k];
    end else if (bus.mem_we) begin
      case (bus.mem_mode)
        2'b10: mem[bus.mem_adr[7:2]][8*bus.mem_adr[1:0] +: 8] <= bus.mem_wd[7:0];
        2'b01: mem[bus.mem_adr[7:2]][16*bus.mem_adr[1] +: 16] <= bus.mem_wd[15:0];
        default: mem[bus.mem_adr[7:2]] <= bus.mem_wd;
      endcase
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    logic exp_i, exp_d, mis, exp_we, elig;
    logic [31:0] w, mask;
    int sh;
    exp_t e;
    if (load) begin
      ref_mem = init;
      starve = 0;
      have_pend = 1'b0;
      sb.delete();
    end else if (reset) begin
      chk("ready_in_reset", {bus.i_ready, bus.d_ready}, 0);
      chk("we_in_reset", bus.mem_we, 0);
      have_pend = 1'b0;
      starve = 0;
      sb.delete();
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL resp_missing actual=none required=cycle %0d", e.cyc);
      end
      if (bus.i_rvalid || bus.d_rvalid) begin
        chk("rvalid_both", bus.i_rvalid & bus.d_rvalid, 0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected actual=rvalid required=none cycle=%0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_cycle", cyc, e.cyc);
          chk("resp_owner", bus.d_rvalid, e.own);
          chk("resp_err", e.own ? bus.d_err : bus.i_err, e.err);
          chk("rdata", bus.rdata, e.rd);
        end
      end
      elig = !have_pend;
      if (have_pend) begin
        mis = pend.own == 1'b0 ? pend.addr % 4 != 0 :
              pend.mode == 2'b01 ? pend.addr % 2 != 0 :
              pend.mode == 2'b10 ? 1'b0 : pend.addr % 4 != 0;
        exp_we = pend.own && pend.we && !mis;
        chk("mem_we_access", bus.mem_we, exp_we);
        chk("mem_adr", bus.mem_adr, pend.addr);
        if (pend.own) begin
          chk("mem_wd", bus.mem_wd, pend.wd);
          chk("mem_mode", bus.mem_mode, pend.mode);
        end
        w = ref_mem[pend.addr[7:2]];
        sb.push_back('{pend.own, mis, w, cyc + 1});
        if (exp_we) begin
          if (pend.mode == 2'b10) begin
            sh = 8 * (pend.addr % 4);
            mask = 32'hFF << sh;
            w = (w & ~mask) | ((pend.wd & 32'hFF) << sh);
          end else if (pend.mode == 2'b01) begin
            sh = 16 * ((pend.addr / 2) % 2);
            mask = 32'hFFFF << sh;
            w = (w & ~mask) | ((pend.wd & 32'hFFFF) << sh);
          end else w = pend.wd;
          ref_mem[pend.addr[7:2]] = w;
        end
        have_pend = 1'b0;
      end else chk("mem_we_idle", bus.mem_we, 0);
      exp_i = elig && bus.i_valid && (!bus.d_valid || starve == 4);
      exp_d = elig && bus.d_valid && !exp_i;
      chk("i_ready", bus.i_ready, exp_i);
      chk("d_ready", bus.d_ready, exp_d);
      if (exp_i) begin
        starve = 0;
        pend = '{1'b0, 1'b0, 2'b00, bus.i_addr, 32'h0, cyc};
        have_pend = 1'b1;
        i_acc_n++;
      end else if (exp_d) begin
        if (bus.i_valid && starve < 4) starve++;
        pend = '{1'b1, bus.d_we, bus.d_mode, bus.d_addr, bus.d_wd, cyc};
        have_pend = 1'b1;
        d_acc_n++;
      end
      if (zchk) begin
        chk("zero_rdata", bus.rdata, 0);
        chk("zero_mem_adr", bus.mem_adr, 0);
        chk("zero_mem_wd", bus.mem_wd, 0);
        chk("zero_ctl", {bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err, bus.mem_we, bus.mem_mode, bus.i_ready, bus.d_ready}, 0);
        chk("mem_word_40", mem[16], ref_mem[16]);
      end
      if (endchk) chk("scoreboard_drained", sb.size() + (have_pend ? 1 : 0), 0);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 255));
    return $urandom_range(0, 3) == 0 ? a : a & 32'hFC;
  endfunction
  task automatic drive(input int pct);
    if (i_acc_n != i_seen || !bus.i_valid) begin
      i_seen = i_acc_n;
      bus.i_valid = $urandom_range(1, 100) <= pct;
      bus.i_addr = raddr();
    end
    if (d_acc_n != d_seen || !bus.d_valid) begin
      d_seen = d_acc_n;
      bus.d_valid = $urandom_range(1, 100) <= pct;
      bus.d_addr = raddr();
      bus.d_we = 1'($urandom_range(0, 1));
      bus.d_mode = 2'($urandom_range(0, 3));
      bus.d_wd = $urandom;
    end
  endtask
  task automatic issue_d(input logic we, input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] wd);
    d_seen = d_acc_n;
    bus.d_valid = 1'b1;
    bus.d_we = we;
    bus.d_mode = mode;
    bus.d_addr = addr;
    bus.d_wd = wd;
    for (int k = 0; k <= 30; k++) begin
      if (k == 30) begin
        $display("FAIL d_accept_timeout actual=no d_ready required=d_ready within 30 cycles");
        $fatal(1);
      end
      step();
      if (d_acc_n != d_seen) break;
    end
    d_seen = d_acc_n;
    bus.d_valid = 1'b0;
  endtask
  task automatic issue_i(input logic [31:0] addr);
    i_seen = i_acc_n;
    bus.i_valid = 1'b1;
    bus.i_addr = addr;
    for (int k = 0; k <= 30; k++) begin
      if (k == 30) begin
        $display("FAIL i_accept_timeout actual=no i_ready required=i_ready within 30 cycles");
        $fatal(1);
      end
      step();
      if (i_acc_n != i_seen) break;
    end
    i_seen = i_acc_n;
    bus.i_valid = 1'b0;
  endtask
  initial begin
    bus.i_valid = 1'b0;
    bus.i_addr = '0;
    bus.d_valid = 1'b0;
    bus.d_addr = '0;
    bus.d_we = 1'b0;
    bus.d_wd = '0;
    bus.d_mode = '0;
    for (int k = 0; k < 64; k++) init[k] = $urandom;
    init[2] = 32'h00500113;
    repeat (3) step();
    load = 1'b0;
    reset = 1'b0;
    zchk = 1'b1;
    step();
    zchk = 1'b0;
    issue_i(32'h8);
    repeat (3) step();
    issue_d(1'b1, 2'b10, 32'h61, 32'hAB);
    issue_d(1'b0, 2'b00, 32'h60, 32'h0);
    issue_d(1'b1, 2'b01, 32'h23, 32'h1234);
    issue_d(1'b0, 2'b00, 32'h20, 32'h0);
    repeat (3) step();
    i_seen = i_acc_n;
    d_seen = d_acc_n;
    for (int k = 0; k < 120; k++) begin
      drive(100);
      step();
    end
    for (int k = 0; k < 500; k++) begin
      drive(50);
      step();
    end
    bus.i_valid = 1'b0;
    bus.d_valid = 1'b0;
    repeat (5) step();
    issue_d(1'b1, 2'b00, 32'h40, 32'hDEADBEEF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    zchk = 1'b1;
    step();
    zchk = 1'b0;
    issue_d(1'b0, 2'b00, 32'h40, 32'h0);
    repeat (5) step();
    endchk = 1'b1;
    step();
    endchk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
